pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the RISC-V core; it replaces the plain PC register. It holds the fetch address and selects the next PC from sequential, branch, jump, trap and trap-return sources, with stall and halt control. It also detects misaligned control-transfer targets, saves the exception PC and counts retired instructions. It sits between the next-PC logic of the execute stage and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC and picks the next one from
// sequential, branch, jump, trap and trap-return sources, with stall and halt.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             trap_req,
    input  logic             mret,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_valid,
    output logic             misaligned,
    output logic [XLEN-1:0]  epc,
    output logic [CNT_W-1:0] instret,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   tgt;
    logic [CNT_W-1:0]  cnt_inc;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Jump targets always have bit 0 dropped; jump beats branch.
    assign tgt = jump ? {jump_target[XLEN-1:1], 1'b0} : branch_target;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt_req) begin
                    pc_d    = pc_plus4;
                    state_d = HALT;
                    cnt_d   = cnt_inc;
                end else if (mret) begin
                    pc_d  = epc_q;
                    cnt_d = cnt_inc;
                end else if (jump || branch_taken) begin
                    if ((tgt & ALIGN_MASK) != '0) begin
                        epc_d = pc_q;
                        pc_d  = TRAP_VECTOR;
                        mis_d = 1'b1;
                    end else begin
                        pc_d  = tgt;
                        cnt_d = cnt_inc;
                    end
                end else begin
                    pc_d  = pc_plus4;
                    cnt_d = cnt_inc;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign instret    = cnt_q;
    assign misaligned = mis_q;
    assign state      = state_q;
    assign pc_valid   = (state_q == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: two instances differing only in ALIGN_BITS,
// expected values queued per step and checked after each clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump, trap_req, mret, halt_req, resume;
    logic [31:0] branch_target, jump_target;

    logic [31:0] a_pc, a_pc4, a_epc;
    logic [3:0]  a_cnt;
    logic [1:0]  a_st;
    logic        a_v, a_mis;
    logic [31:0] b_pc, b_pc4, b_epc;
    logic [3:0]  b_cnt;
    logic [1:0]  b_st;
    logic        b_v, b_mis;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [3:0]  cnt;
        logic [1:0]  st;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h1000), .TRAP_VECTOR(32'h100),
        .ALIGN_BITS(2), .CNT_W(4)
    ) u_a (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap_req(trap_req),
        .mret(mret), .halt_req(halt_req), .resume(resume),
        .pc(a_pc), .pc_plus4(a_pc4), .pc_valid(a_v), .misaligned(a_mis),
        .epc(a_epc), .instret(a_cnt), .state(a_st)
    );

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h1000), .TRAP_VECTOR(32'h100),
        .ALIGN_BITS(1), .CNT_W(4)
    ) u_b (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap_req(trap_req),
        .mret(mret), .halt_req(halt_req), .resume(resume),
        .pc(b_pc), .pc_plus4(b_pc4), .pc_valid(b_v), .misaligned(b_mis),
        .epc(b_epc), .instret(b_cnt), .state(b_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall = 0; branch_taken = 0; jump = 0; trap_req = 0;
        mret = 0; halt_req = 0; resume = 0;
        branch_target = '0; jump_target = '0;
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic [31:0] epc, input logic [3:0] cnt,
                        input logic [1:0] st, input logic mis);
        exp_t e;
        e.tag = tag; e.pc = pc; e.epc = epc;
        e.cnt = cnt; e.st = st; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".pc"}, a_pc, e.pc);
        chk({e.tag, ".pc4"}, a_pc4, e.pc + 32'd4);
        chk({e.tag, ".epc"}, a_epc, e.epc);
        chk({e.tag, ".cnt"}, {28'd0, a_cnt}, {28'd0, e.cnt});
        chk({e.tag, ".st"}, {30'd0, a_st}, {30'd0, e.st});
        chk({e.tag, ".vld"}, {31'd0, a_v}, {31'd0, e.st == 2'd1});
        chk({e.tag, ".mis"}, {31'd0, a_mis}, {31'd0, e.mis});
    endtask

    // Check current outputs without a clock edge.
    task automatic snap(input string tag, input logic [31:0] pc,
                        input logic [31:0] epc, input logic [3:0] cnt,
                        input logic [1:0] st, input logic mis);
        push(tag, pc, epc, cnt, st, mis);
        pop_cmp();
    endtask

    // Queue expectation for the inputs now driven, clock once, compare.
    task automatic step(input string tag, input logic [31:0] pc,
                        input logic [31:0] epc, input logic [3:0] cnt,
                        input logic [1:0] st, input logic mis);
        push(tag, pc, epc, cnt, st, mis);
        @(posedge clk);
        #1;
        pop_cmp();
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b0;
        #2 reset = 1'b1;
        #10;
        snap("rst", 32'h1000, 0, 0, 2'd0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        snap("boot", 32'h1000, 0, 0, 2'd0, 0);
        step("run0", 32'h1000, 0, 0, 2'd1, 0);
        step("seq1", 32'h1004, 0, 1, 2'd1, 0);
        step("seq2", 32'h1008, 0, 2, 2'd1, 0);

        branch_taken = 1; branch_target = 32'h2000;
        step("br", 32'h2000, 0, 3, 2'd1, 0);
        jump = 1; jump_target = 32'h3001;
        step("jmp", 32'h3000, 0, 4, 2'd1, 0);
        jump = 1; jump_target = 32'h4000;
        branch_taken = 1; branch_target = 32'h5000;
        step("jmp_br", 32'h4000, 0, 5, 2'd1, 0);

        branch_taken = 1; branch_target = 32'h2002;
        step("mis_a", 32'h100, 32'h4000, 5, 2'd1, 1);
        chk("mis_b.pc", b_pc, 32'h2002);
        chk("mis_b.cnt", {28'd0, b_cnt}, 32'd6);
        chk("mis_b.mis", {31'd0, b_mis}, 32'd0);
        step("mis_clr", 32'h104, 32'h4000, 6, 2'd1, 0);

        jump = 1; jump_target = 32'h40;
        step("to40", 32'h40, 32'h4000, 7, 2'd1, 0);
        for (int i = 0; i < 3; i++) begin
            stall = 1; branch_taken = 1; branch_target = 32'h800;
            step("stall", 32'h40, 32'h4000, 7, 2'd1, 0);
        end
        stall = 1; trap_req = 1;
        step("trap_stall", 32'h100, 32'h40, 7, 2'd1, 0);
        mret = 1;
        step("mret", 32'h40, 32'h40, 8, 2'd1, 0);

        jump = 1; jump_target = 32'h80;
        step("to80", 32'h80, 32'h40, 9, 2'd1, 0);
        halt_req = 1;
        step("halt", 32'h84, 32'h40, 10, 2'd2, 0);
        trap_req = 1;
        step("halt_trap", 32'h84, 32'h40, 10, 2'd2, 0);
        resume = 1;
        step("resume", 32'h84, 32'h40, 10, 2'd1, 0);
        step("wr11", 32'h88, 32'h40, 11, 2'd1, 0);
        step("wr12", 32'h8c, 32'h40, 12, 2'd1, 0);
        step("wr13", 32'h90, 32'h40, 13, 2'd1, 0);
        step("wr14", 32'h94, 32'h40, 14, 2'd1, 0);
        step("wr15", 32'h98, 32'h40, 15, 2'd1, 0);
        step("wrap0", 32'h9c, 32'h40, 0, 2'd1, 0);

        jump = 1; jump_target = 32'hFFFF_FFFC;
        step("top", 32'hFFFF_FFFC, 32'h40, 1, 2'd1, 0);
        step("pcwrap", 32'h0, 32'h40, 2, 2'd1, 0);
        halt_req = 1;
        step("halt2", 32'h4, 32'h40, 3, 2'd2, 0);

        #2 reset = 1'b1;
        #1;
        snap("async_rst", 32'h1000, 0, 0, 2'd0, 0);
        @(negedge clk);
        reset = 1'b0;
        step("rerun", 32'h1000, 0, 0, 2'd1, 0);
        step("reseq", 32'h1004, 0, 1, 2'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
